// File: rtl/alu_exec_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_exec_if
// Purpose  : Upstream op/operand handshake and downstream result handshake
//            bundle for alu_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   aluoperation;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal_op;

    // Producer side: issues ops and consumes results
    modport master (
        output in_valid, aluoperation, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal_op
    );

    // Execution unit side
    modport slave (
        input  in_valid, aluoperation, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Registered ALU execution stage. AND/OR/ADD/SUB/SLT complete in
//            one cycle; unsupported opcodes complete as illegal with a zero
//            result. Results are held under a valid/ready handshake.
// Options  : ALU_EXEC_MUL_EN - adds opcode 1000, a serial shift-add unsigned
//            multiply (low WIDTH bits) taking WIDTH+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_exec_if.slave bus
);

    localparam logic [OPW-1:0] c_op_and = OPW'(4'b0000);
    localparam logic [OPW-1:0] c_op_or  = OPW'(4'b0001);
    localparam logic [OPW-1:0] c_op_add = OPW'(4'b0010);
    localparam logic [OPW-1:0] c_op_sub = OPW'(4'b0110);
    localparam logic [OPW-1:0] c_op_slt = OPW'(4'b0111);
`ifdef ALU_EXEC_MUL_EN
    localparam logic [OPW-1:0] c_op_mul = OPW'(4'b1000);
    localparam int             c_cw     = $clog2(WIDTH + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

`ifdef ALU_EXEC_MUL_EN
    logic [c_cw-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             w_is_mul;
`endif

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ov;
    logic             w_alu_ill;

    // A new op can enter when idle, or when the held result leaves this edge
    assign w_in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_sum  = bus.operand_a + bus.operand_b;
    assign w_diff = bus.operand_a - bus.operand_b;
    assign w_slt  = $signed(bus.operand_a) < $signed(bus.operand_b);

    // Single-cycle datapath evaluated directly on the incoming operands
    always_comb begin
        w_alu_res = '0;
        w_alu_ov  = 1'b0;
        w_alu_ill = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        w_is_mul  = 1'b0;
`endif
        case (bus.aluoperation)
            c_op_and: w_alu_res = bus.operand_a & bus.operand_b;
            c_op_or:  w_alu_res = bus.operand_a | bus.operand_b;
            c_op_add: begin
                w_alu_res = w_sum;
                w_alu_ov  = (bus.operand_a[WIDTH-1] == bus.operand_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != bus.operand_a[WIDTH-1]);
            end
            c_op_sub: begin
                w_alu_res = w_diff;
                w_alu_ov  = (bus.operand_a[WIDTH-1] != bus.operand_b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != bus.operand_a[WIDTH-1]);
            end
            c_op_slt: w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
`ifdef ALU_EXEC_MUL_EN
            c_op_mul: w_is_mul = 1'b1;
`endif
            default:  w_alu_ill = 1'b1;
        endcase
    end

    // Next-state and next-output logic; everything holds unless changed
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
`ifdef ALU_EXEC_MUL_EN
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
`endif
        case (state_q)
            S_IDLE, S_HOLD: begin
                if ((state_q == S_HOLD) && bus.out_ready) begin
                    state_d = S_IDLE;
                end
                if (w_accept) begin
`ifdef ALU_EXEC_MUL_EN
                    if (w_is_mul) begin
                        state_d  = S_EXEC;
                        cnt_d    = c_cw'(WIDTH);
                        acc_d    = '0;
                        mcand_d  = bus.operand_a;
                        mplier_d = bus.operand_b;
                    end else
`endif
                    begin
                        state_d    = S_HOLD;
                        result_d   = w_alu_res;
                        zero_d     = (w_alu_res == '0);
                        overflow_d = w_alu_ov;
                        illegal_d  = w_alu_ill;
                    end
                end
            end
`ifdef ALU_EXEC_MUL_EN
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d    = S_HOLD;
                    result_d   = acc_q;
                    zero_d     = (acc_q == '0);
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                end else begin
                    // One multiplier bit per cycle, LSB first
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - c_cw'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

`ifdef ALU_EXEC_MUL_EN
    // Serial multiplier working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (state_q == S_HOLD);
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.overflow   = overflow_q;
    assign bus.illegal_op = illegal_q;

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU operation code that the ALU control decoder produces.
- Registers operands and opcode through a valid/ready handshake.
- Executes AND, OR, ADD, SUB and SLT with a registered result. Multiply is an optional multi-cycle operation.
- Sits between the decode/control stage and writeback. It presents result, zero and overflow flags under a downstream valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4)
- OPW, 4, width of the aluoperation code

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has op + operands
- in_ready  out  1  unit can accept an op this cycle
- aluoperation  in  OPW  op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MUL (optional)
- operand_a  in  WIDTH  first operand
- operand_b  in  WIDTH  second operand
- out_valid  out  1  result/flags valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- illegal_op  out  1  opcode unsupported; result forced to 0

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; in_ready=1; out_valid=0; result=0; zero=0; overflow=0; illegal_op=0; internal counter/accumulator=0.
- Reset mid-operation aborts the op immediately, nothing emitted; the first edge after deassertion is in IDLE.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - EXEC: multi-cycle op in progress; in_ready=0, out_valid=0.
  - HOLD: out_valid=1, outputs stable.
- Accept: in_valid&&in_ready at an edge latches aluoperation, operand_a and operand_b.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/illegal):
  - Result and flags are registered at the accept edge; go to HOLD.
  - out_valid rises 1 cycle after accept.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH.
  - overflow for ADD = sign(a)==sign(b) && sign(r)!=sign(a).
  - overflow for SUB = sign(a)!=sign(b) && sign(r)!=sign(a).
  - SLT is a signed compare; result = {WIDTH-1 zeros, a<b}.
  - zero is computed from the final result for every op, including illegal.
- Illegal opcode: result=0, zero=1, overflow=0, illegal_op=1; completes like a single-cycle op and is never dropped.
- HOLD:
  - result, zero, overflow and illegal_op are held stable while out_valid&&!out_ready.
  - On out_ready, go to IDLE.
- Back-to-back: in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - A new op accepted on the same edge as the result handoff gives out_valid continuously high with the new result next cycle.
  - Sustained throughput is one single-cycle op per clock.
- in_valid with in_ready=0: the input is ignored; upstream must hold it.
- Inputs outside an accept edge do not affect outputs.

Optional Feature:
- Macro: ALU_EXEC_MUL_EN.
- Defined:
  - Op 1000 is a serial shift-add unsigned multiply, low WIDTH bits of the product.
  - Accept edge goes to EXEC with a counter loaded to WIDTH.
  - One multiplier bit is consumed per cycle. When the counter reaches 0, result is registered and the FSM goes to HOLD.
  - out_valid rises exactly WIDTH+1 cycles after accept.
  - overflow=0 and illegal_op=0 for MUL.
- Undefined: 1000 is treated as an illegal opcode; the EXEC state and counter are not implemented.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> in_ready=1, out_valid=0, result=0, all flags 0. Release mid-cycle (async) -> state holds IDLE.
- ADD overflow, WIDTH=32: a=0x7FFFFFFF, b=1, op 0010 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0. SUB: a=5, b=5, op 0110 -> result=0, zero=1, overflow=0.
- Logic/SLT: AND 0xF0F0_F0F0 & 0x0FF0_0FF0 -> 0x00F0_00F0. OR same operands -> 0xFFF0_FFF0. SLT a=0xFFFFFFFF (−1), b=1 -> result=1.
- Backpressure/back-to-back: out_ready=0 for 4 cycles -> result stable, in_ready=0. Then out_ready=1 with a new in_valid (ADD 2+3) on the same cycle -> out_valid stays 1, next result=5. Stream 8 ADDs with out_ready=1 -> 8 results on 8 consecutive cycles.
- Illegal op: op 1111, a=9, b=9 -> result=0, zero=1, illegal_op=1, out_valid after 1 cycle. Op 1000 without ALU_EXEC_MUL_EN -> same response.
- ALU_EXEC_MUL_EN checks:
  - 0x0001_0003 * 0x0000_0005 -> out_valid exactly 33 cycles after accept, result=0x0005_000F.
  - rst_n asserted at cycle 10 of EXEC -> out_valid never rises; IDLE after reset.
